// File: rtl/ecc_sed_decoder.sv
// SED receive checker: strips the parity bit, flags odd-parity words; 1-cycle latency, 2-entry skid buffer, enc_ready drops only when both entries are full.
// Error counter err_cnt is built only when ECC_SED_DEC_ERR_CNT_EN is defined, otherwise tied to zero.
module ecc_sed_decoder #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enc_valid,
  output logic              enc_ready,
  input  logic [DATA_W:0]   enc_codeword,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [DATA_W-1:0] dec_data,
  output logic              dec_err,
  output logic              err_sticky,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t              state;
  logic [DATA_W-1:0]   head_dat, tail_dat;
  logic                head_err, tail_err;
  logic                accept, deliver, in_err, deliver_err;

  assign accept      = enc_valid & enc_ready;
  assign deliver     = dec_valid & dec_ready;
  assign in_err      = ^enc_codeword;
  assign deliver_err = deliver & head_err;
  assign dec_data    = head_dat;
  assign dec_err     = head_err;

  // head always holds the oldest word; tail is only occupied in TWO
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      enc_ready <= 1'b1;
      dec_valid <= 1'b0;
      head_dat  <= '0;
      head_err  <= 1'b0;
      tail_dat  <= '0;
      tail_err  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            head_dat  <= enc_codeword[DATA_W-1:0];
            head_err  <= in_err;
            state     <= ONE;
            enc_ready <= 1'b1;
            dec_valid <= 1'b1;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            head_dat <= enc_codeword[DATA_W-1:0];
            head_err <= in_err;
          end else if (accept) begin
            tail_dat  <= enc_codeword[DATA_W-1:0];
            tail_err  <= in_err;
            state     <= TWO;
            enc_ready <= 1'b0;
          end else if (deliver) begin
            state     <= EMPTY;
            dec_valid <= 1'b0;
          end
        end
        TWO: begin
          if (deliver) begin
            head_dat  <= tail_dat;
            head_err  <= tail_err;
            state     <= ONE;
            enc_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          enc_ready <= 1'b1;
          dec_valid <= 1'b0;
        end
      endcase
    end
  end

  // err_clr wins first, then the same-cycle errored delivery is recorded
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (err_clr) begin
      err_sticky <= deliver_err;
    end else if (deliver_err) begin
      err_sticky <= 1'b1;
    end
  end

`ifdef ECC_SED_DEC_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (err_clr) begin
      cnt_q <= deliver_err ? CNT_ONE : '0;
    end else if (deliver_err && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ecc_sed_decoder.sv
// Directed bench for ecc_sed_decoder with a 4-bit error counter to reach saturation quickly.
module tb_ecc_sed_decoder;

  localparam int DATA_W = 12;
  localparam int CNT_W  = 4;
`ifdef ECC_SED_DEC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              enc_valid;
  logic              enc_ready;
  logic [DATA_W:0]   enc_codeword;
  logic              dec_valid;
  logic              dec_ready;
  logic [DATA_W-1:0] dec_data;
  logic              dec_err;
  logic              err_sticky;
  logic              err_clr;
  logic [CNT_W-1:0]  err_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  ecc_sed_decoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .enc_valid    (enc_valid),
    .enc_ready    (enc_ready),
    .enc_codeword (enc_codeword),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_data     (dec_data),
    .dec_err      (dec_err),
    .err_sticky   (err_sticky),
    .err_clr      (err_clr),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    return CNT_EN ? n : 0;
  endfunction

  initial begin
    rst          = 1'b1;
    enc_valid    = 1'b0;
    enc_codeword = '0;
    dec_ready    = 1'b0;
    err_clr      = 1'b0;

    // 1. reset
    tick();
    tick();
    rst = 1'b0;
    check("rst_dec_valid", dec_valid, 0);
    check("rst_enc_ready", enc_ready, 1);
    check("rst_sticky", err_sticky, 0);
    check("rst_cnt", err_cnt, 0);
    check("rst_dec_data", dec_data, 0);
    check("rst_dec_err", dec_err, 0);

    // 2. clean word, 1-cycle latency
    dec_ready    = 1'b1;
    enc_valid    = 1'b1;
    enc_codeword = {1'b0, 12'hA5A};
    tick();
    enc_valid = 1'b0;
    check("t2_valid", dec_valid, 1);
    check("t2_data", dec_data, 12'hA5A);
    check("t2_err", dec_err, 0);
    tick();
    check("t2_drained", dec_valid, 0);
    check("t2_cnt", err_cnt, 0);
    check("t2_sticky", err_sticky, 0);

    // 3. parity error
    enc_valid    = 1'b1;
    enc_codeword = {1'b1, 12'hA5A};
    tick();
    enc_valid = 1'b0;
    check("t3_valid", dec_valid, 1);
    check("t3_err", dec_err, 1);
    check("t3_sticky_pre", err_sticky, 0);
    tick();
    check("t3_sticky", err_sticky, 1);
    check("t3_cnt", err_cnt, exp_cnt(1));

    // 4. backpressure: three words offered, two fit
    dec_ready    = 1'b0;
    enc_valid    = 1'b1;
    enc_codeword = {1'b0, 12'h003};
    tick();
    check("t4_rdy_after1", enc_ready, 1);
    enc_codeword = {1'b0, 12'h00F};
    tick();
    check("t4_rdy_after2", enc_ready, 0);
    enc_codeword = {1'b0, 12'h0F0};
    tick();
    check("t4_rdy_held", enc_ready, 0);
    check("t4_stable_data", dec_data, 12'h003);
    check("t4_stable_valid", dec_valid, 1);
    dec_ready = 1'b1;
    tick();
    check("t4_word1", dec_data, 12'h00F);
    check("t4_rdy_reopen", enc_ready, 1);
    tick();
    enc_valid = 1'b0;
    check("t4_word2", dec_data, 12'h0F0);
    check("t4_word2_err", dec_err, 0);
    tick();
    check("t4_empty", dec_valid, 0);
    check("t4_cnt", err_cnt, exp_cnt(1));

    // 5. saturation: 20 more errored words streamed
    enc_codeword = {1'b1, 12'h000};
    enc_valid    = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    enc_valid = 1'b0;
    tick();
    check("t5_empty", dec_valid, 0);
    check("t5_cnt_sat", err_cnt, exp_cnt(15));
    check("t5_sticky", err_sticky, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t5_clr_cnt", err_cnt, 0);
    check("t5_clr_sticky", err_sticky, 0);

    // 6. clear coinciding with errored delivery
    enc_valid = 1'b1;
    tick();
    tick();
    enc_valid = 1'b0;
    check("t6_cnt_before", err_cnt, exp_cnt(1));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t6_clr_sticky", err_sticky, 1);
    check("t6_clr_cnt", err_cnt, exp_cnt(1));
    check("t6_empty", dec_valid, 0);

    // 6b. reset with two words buffered, inputs ignored during reset
    dec_ready    = 1'b0;
    enc_valid    = 1'b1;
    enc_codeword = {1'b1, 12'h555};
    tick();
    tick();
    check("t6_full_rdy", enc_ready, 0);
    check("t6_full_valid", dec_valid, 1);
    rst       = 1'b1;
    dec_ready = 1'b1;
    tick();
    check("t6_rst_valid", dec_valid, 0);
    check("t6_rst_rdy", enc_ready, 1);
    check("t6_rst_sticky", err_sticky, 0);
    check("t6_rst_cnt", err_cnt, 0);
    check("t6_rst_data", dec_data, 0);
    enc_valid = 1'b0;
    rst       = 1'b0;
    tick();
    check("t6_post_valid", dec_valid, 0);
    check("t6_post_sticky", err_sticky, 0);
    check("t6_post_cnt", err_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
